// File: rtl/line_fill_if.sv
// Bundle of request, write, and line-return signals between the cache side
// (master) and the line-fill memory (slave).
interface line_fill_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  line_valid;
    logic                  line_ready;
    logic [ADDR_W-1:0]     line_addr;
    logic [4*DATA_W-1:0]   line_data;
    logic                  busy;
    logic [15:0]           fill_count;

    modport master (
        output req_valid, req_addr, wr_en, wr_addr, wr_data, line_ready,
        input  req_ready, line_valid, line_addr, line_data, busy, fill_count
    );

    modport slave (
        input  req_valid, req_addr, wr_en, wr_addr, wr_data, line_ready,
        output req_ready, line_valid, line_addr, line_data, busy, fill_count
    );
endinterface

// File: rtl/line_fill_memory.sv
// Backing memory plus line-fill controller: accepts a line request, waits a
// fixed latency, then returns the aligned 4-word line and counts fills.
module line_fill_memory #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst,
    line_fill_if.slave   bus
);
    localparam int         BANK_W   = ADDR_W - 2;
    localparam logic [3:0] CNT_LOAD = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_W-1:0]     line_addr_q, line_addr_d;
    logic [4*DATA_W-1:0]   line_data_q, line_data_d;
    logic [15:0]           fill_count_q, fill_count_d;

    // Base of the line being read this cycle: the incoming request while
    // idle (LATENCY = 1 reads on the acceptance edge), otherwise the held one.
    logic [ADDR_W-1:0]     fill_base;
    logic [4*DATA_W-1:0]   fill_data;

    assign fill_base = (state_q == IDLE) ? {bus.req_addr[ADDR_W-1:2], 2'b00}
                                         : line_addr_q;

    // Memory is split into four word-interleaved banks so a whole line can be
    // read in one cycle; each bank holds the words with matching addr[1:0].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            localparam logic [1:0] WORD_SEL = 2'(gi);
            logic [DATA_W-1:0] bank_mem [2**BANK_W];

            // Writes are never blocked and are not affected by reset.
            always_ff @(posedge clk) begin
                if (bus.wr_en && (bus.wr_addr[1:0] == WORD_SEL)) begin
                    bank_mem[bus.wr_addr[ADDR_W-1:2]] <= bus.wr_data;
                end
            end

            // Write-first forwarding so a same-cycle write lands in the line.
            assign fill_data[DATA_W*gi +: DATA_W] =
                (bus.wr_en && (bus.wr_addr == {fill_base[ADDR_W-1:2], WORD_SEL}))
                    ? bus.wr_data
                    : bank_mem[fill_base[ADDR_W-1:2]];
        end
    endgenerate

    // Controller state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            line_addr_q  <= '0;
            line_data_q  <= '0;
            fill_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_addr_q  <= line_addr_d;
            line_data_q  <= line_data_d;
            fill_count_q <= fill_count_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, hold line in RESP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_addr_d  = line_addr_q;
        line_data_d  = line_data_q;
        fill_count_d = fill_count_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    line_addr_d = fill_base;
                    if (LATENCY == 1) begin
                        state_d     = RESP;
                        line_data_d = fill_data;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    line_data_d = fill_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.line_ready) begin
                    state_d = IDLE;
                    if (fill_count_q != 16'hFFFF) begin
                        fill_count_d = fill_count_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.line_valid = (state_q == RESP);
    assign bus.line_addr  = line_addr_q;
    assign bus.line_data  = line_data_q;
    assign bus.fill_count = fill_count_q;
endmodule

// File: tb/tb_line_fill_memory.sv
// Directed bench: stimulus pushes expected lines into per-DUT queues, a
// monitor per DUT pops and compares on every line handshake.
module tb_line_fill_memory;
    localparam int AW = 15;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_fill_if #(.ADDR_W(AW), .DATA_W(DW)) bus0();
    line_fill_if #(.ADDR_W(AW), .DATA_W(DW)) bus1();

    line_fill_memory #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(4)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    line_fill_memory #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        logic [AW-1:0]   addr;
        logic [4*DW-1:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [4*DW-1:0] act,
                         input logic [4*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [4*DW-1:0] line4(input logic [DW-1:0] w0, w1, w2, w3);
        return {w3, w2, w1, w0};
    endfunction

    // Monitors: sample mid-cycle; valid && ready here means a handshake on
    // the coming rising edge.
    exp_t e0, e1;
    initial forever begin
        @(negedge clk);
        if (bus0.line_valid === 1'b1 && bus0.line_ready === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon0_unexpected: line at %0h with nothing expected", bus0.line_addr);
            end else begin
                e0 = q0.pop_front();
                check("mon0_line_addr", 128'(bus0.line_addr), 128'(e0.addr));
                check("mon0_line_data", bus0.line_data, e0.data);
            end
        end
    end
    initial forever begin
        @(negedge clk);
        if (bus1.line_valid === 1'b1 && bus1.line_ready === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon1_unexpected: line at %0h with nothing expected", bus1.line_addr);
            end else begin
                e1 = q1.pop_front();
                check("mon1_line_addr", 128'(bus1.line_addr), 128'(e1.addr));
                check("mon1_line_data", bus1.line_data, e1.data);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus0.wr_en = 1'b1; bus0.wr_addr = a; bus0.wr_data = d;
        tick();
        bus0.wr_en = 1'b0;
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus1.wr_en = 1'b1; bus1.wr_addr = a; bus1.wr_data = d;
        tick();
        bus1.wr_en = 1'b0;
    endtask

    task automatic accept0(input logic [AW-1:0] a);
        check("acc0_req_ready", 128'(bus0.req_ready), 128'(1));
        bus0.req_valid = 1'b1; bus0.req_addr = a;
        tick();
        bus0.req_valid = 1'b0;
    endtask

    // Consumer sees line_valid at edge (accept + lat).
    task automatic wait0(output int lat);
        int k = 0;
        while (bus0.line_valid !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        lat = k + 1;
    endtask

    task automatic req0(input logic [AW-1:0] a, output int lat);
        accept0(a);
        wait0(lat);
    endtask

    task automatic req1(input logic [AW-1:0] a, output int lat);
        int k = 0;
        check("acc1_req_ready", 128'(bus1.req_ready), 128'(1));
        bus1.req_valid = 1'b1; bus1.req_addr = a;
        tick();
        bus1.req_valid = 1'b0;
        while (bus1.line_valid !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        lat = k + 1;
    endtask

    initial begin
        int lat;
        int nacc;
        int prev_acc;
        logic [4*DW-1:0] exp_line;

        bus0.req_valid = 0; bus0.req_addr = '0; bus0.wr_en = 0;
        bus0.wr_addr = '0; bus0.wr_data = '0; bus0.line_ready = 0;
        bus1.req_valid = 0; bus1.req_addr = '0; bus1.wr_en = 0;
        bus1.wr_addr = '0; bus1.wr_data = '0; bus1.line_ready = 0;

        // Reset, with the first preload done while reset is held.
        #1;
        wr0(15'h0100, 32'hA0);
        wr0(15'h0101, 32'hA1);
        wr0(15'h0102, 32'hA2);
        wr0(15'h0103, 32'hA3);
        check("rst_req_ready",  128'(bus0.req_ready),  128'(1));
        check("rst_line_valid", 128'(bus0.line_valid), 128'(0));
        check("rst_busy",       128'(bus0.busy),       128'(0));
        check("rst_line_addr",  128'(bus0.line_addr),  128'(0));
        check("rst_line_data",  bus0.line_data,        128'(0));
        check("rst_fill_count", 128'(bus0.fill_count), 128'(0));
        rst = 1'b0;
        tick();

        // Basic fill from a mid-line address.
        bus0.line_ready = 1'b1;
        q0.push_back('{addr: 15'h0100, data: line4(32'hA0, 32'hA1, 32'hA2, 32'hA3)});
        req0(15'h0102, lat);
        check("t1_latency", 128'(lat), 128'(4));
        check("t1_line_addr", 128'(bus0.line_addr), 128'(15'h0100));
        tick();
        check("t1_fill_count", 128'(bus0.fill_count), 128'(1));
        check("t1_valid_drop", 128'(bus0.line_valid), 128'(0));

        // Back-pressure: hold the line, write under it, then handshake.
        bus0.line_ready = 1'b0;
        exp_line = line4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        q0.push_back('{addr: 15'h0100, data: exp_line});
        req0(15'h0100, lat);
        check("t2_latency", 128'(lat), 128'(4));
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 128'(bus0.line_valid), 128'(1));
            check("t2_hold_data", bus0.line_data, exp_line);
            if (i == 2) wr0(15'h0101, 32'hFF);
            else        tick();
        end
        check("t2_after_write_data", bus0.line_data, exp_line);
        check("t2_hold_count", 128'(bus0.fill_count), 128'(1));
        bus0.line_ready = 1'b1;
        tick();
        check("t2_fill_count", 128'(bus0.fill_count), 128'(2));

        // Write during WAIT lands in the returned line.
        wr0(15'h0200, 32'hB0);
        wr0(15'h0201, 32'hB1);
        wr0(15'h0202, 32'hB2);
        wr0(15'h0203, 32'hB3);
        q0.push_back('{addr: 15'h0200, data: line4(32'hB0, 32'hB1, 32'hB2, 32'h1234)});
        accept0(15'h0200);
        wr0(15'h0203, 32'h1234);
        wait0(lat);
        check("t3a_valid", 128'(bus0.line_valid), 128'(1));
        tick();

        // Write on the very edge that enters RESP is forwarded.
        wr0(15'h0203, 32'hDEAD);
        q0.push_back('{addr: 15'h0200, data: line4(32'hB0, 32'hB1, 32'hB2, 32'h1234)});
        accept0(15'h0200);
        tick();
        tick();
        bus0.wr_en = 1'b1; bus0.wr_addr = 15'h0203; bus0.wr_data = 32'h1234;
        tick();
        bus0.wr_en = 1'b0;
        check("t3b_valid_at_entry", 128'(bus0.line_valid), 128'(1));
        tick();
        check("t3_fill_count", 128'(bus0.fill_count), 128'(4));

        // req_valid held: one acceptance per fill, spaced LATENCY+1 apart.
        bus0.line_ready = 1'b1;
        bus0.req_valid  = 1'b1;
        bus0.req_addr   = 15'h0101;
        nacc = 0;
        prev_acc = -1;
        for (int c = 0; c < 20; c++) begin
            check("t4_ready_and_busy", 128'(bus0.req_ready & bus0.busy), 128'(0));
            if (bus0.req_ready === 1'b1) begin
                if (prev_acc >= 0) check("t4_spacing", 128'(c - prev_acc), 128'(5));
                prev_acc = c;
                nacc++;
                q0.push_back('{addr: 15'h0100, data: line4(32'hA0, 32'hFF, 32'hA2, 32'hA3)});
            end
            tick();
        end
        bus0.req_valid = 1'b0;
        check("t4_accept_count", 128'(nacc), 128'(4));
        for (int k = 0; k < 20 && bus0.busy === 1'b1; k++) tick();
        check("t4_drained_busy", 128'(bus0.busy), 128'(0));
        check("t4_fill_count", 128'(bus0.fill_count), 128'(8));

        // Reset mid-WAIT drops the request but keeps memory.
        accept0(15'h0100);
        tick();
        check("t5_in_wait_busy", 128'(bus0.busy), 128'(1));
        rst = 1'b1;
        #1;
        check("t5_rst_req_ready",  128'(bus0.req_ready),  128'(1));
        check("t5_rst_busy",       128'(bus0.busy),       128'(0));
        check("t5_rst_line_valid", 128'(bus0.line_valid), 128'(0));
        check("t5_rst_fill_count", 128'(bus0.fill_count), 128'(0));
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("t5_no_line_valid", 128'(bus0.line_valid), 128'(0));
            tick();
        end
        q0.push_back('{addr: 15'h0100, data: line4(32'hA0, 32'hFF, 32'hA2, 32'hA3)});
        req0(15'h0100, lat);
        check("t5_latency", 128'(lat), 128'(4));
        tick();
        check("t5_fill_count", 128'(bus0.fill_count), 128'(1));

        // LATENCY = 1 instance: top-of-memory line and counter saturation.
        wr1(15'h7FFC, 32'hC0);
        wr1(15'h7FFD, 32'hC1);
        wr1(15'h7FFE, 32'hC2);
        wr1(15'h7FFF, 32'hC3);
        bus1.line_ready = 1'b1;
        q1.push_back('{addr: 15'h7FFC, data: line4(32'hC0, 32'hC1, 32'hC2, 32'hC3)});
        req1(15'h7FFE, lat);
        check("t6_latency", 128'(lat), 128'(1));
        check("t6_line_addr", 128'(bus1.line_addr), 128'(15'h7FFC));
        tick();
        check("t6_fill_count", 128'(bus1.fill_count), 128'(1));
        force dut1.fill_count_q = 16'hFFFF;
        #1;
        release dut1.fill_count_q;
        check("t6_forced_count", 128'(bus1.fill_count), 128'(16'hFFFF));
        q1.push_back('{addr: 15'h7FFC, data: line4(32'hC0, 32'hC1, 32'hC2, 32'hC3)});
        req1(15'h7FFC, lat);
        check("t6_latency2", 128'(lat), 128'(1));
        tick();
        check("t6_saturated", 128'(bus1.fill_count), 128'(16'hFFFF));
        check("t6_idle", 128'(bus1.req_ready), 128'(1));

        tick();
        check("queues_drained", 128'(q0.size() + q1.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
